operand_sequencer: RTL and testbench
====================================

Name: operand_sequencer

Overview:
- Sequences operand parsing for one assembly line after the mnemonic has been decoded.
- Takes the instruction format code and routes the incoming ASCII stream to the shared register interpreter or the shared immediate interpreter, one operand at a time in format order.
- Gates each interpreter's valid_data, latches the returned fields into rd/rs1/rs2/imm, and reports line completion or error to the line-level assembler controller.

Parameters:
- IMM_WIDTH, 32, width of the immediate value returned by the immediate interpreter.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; begins operand sequencing with format_in.
- format_in  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- line_valid  input  1  upstream line still valid; low aborts.
- new_character  input  1  incoming_ascii holds a new character this cycle.
- incoming_ascii  input  8  current character.
- reg_done  input  1  register interpreter done_flag.
- reg_error  input  1  register interpreter error_flag.
- reg_value  input  5  register interpreter result.
- imm_done  input  1  immediate interpreter done_flag (same contract as reg_done).
- imm_error  input  1  immediate interpreter error_flag.
- imm_value  input  IMM_WIDTH  immediate interpreter result.
- reg_valid  output  1  valid_data to the register interpreter.
- imm_valid  output  1  valid_data to the immediate interpreter.
- rd, rs1, rs2  output  5 each  latched register fields.
- imm  output  IMM_WIDTH  latched immediate.
- busy  output  1  high in OPERAND.
- done  output  1  one-cycle pulse on successful line.
- error  output  1  level; held until next start or reset.

Behaviour:
- Reset: state IDLE, op_idx=0; rd/rs1/rs2=0, imm=0, busy=0, done=0, error=0, reg_valid=0, imm_valid=0.
- Operand order (slot 0,1,2):
  - R: rd, rs1, rs2
  - I: rd, rs1, imm
  - S: rs2, rs1, imm
  - B: rs1, rs2, imm
  - U: rd, imm
  - J: rd, imm
  - Operand count is 3 for R/I/S/B and 2 for U/J.
- States: IDLE, OPERAND, DONE, ERROR.
- IDLE / DONE / ERROR + start:
  - Legal format: capture it, op_idx=0, clear rd/rs1/rs2/imm to 0, clear error, go to OPERAND.
  - Illegal format: go to ERROR.
  - start has priority in every state, including OPERAND, where it restarts.
- OPERAND routing (combinational from registered state):
  - reg_valid = line_valid when the current slot is a register.
  - imm_valid = line_valid when the current slot is the immediate.
  - Both are 0 in all other states.
- Latching:
  - While sel_done (reg_done or imm_done of the current slot type) is high, write reg_value/imm_value into the slot's field every cycle.
  - The final value is whatever is held when the terminating character arrives.
- Delimiter (new_character with " " or ","):
  - sel_done=1 and slot not last: op_idx+1, taking effect the next cycle. The interpreter itself consumes the delimiter the same cycle and returns to IDLE.
  - sel_done=1 and slot last: ERROR (extra operand).
  - sel_done=0: no action (leading or extra spaces are ignored by the interpreter).
- Newline (new_character with 0x0A):
  - sel_done=1 and slot last: go to DONE.
  - Otherwise: ERROR (missing operand).
- reg_error or imm_error for the active slot: ERROR the next cycle.
- line_valid=0 in OPERAND: back to IDLE, no done, no error.
- DONE lasts one cycle with done=1, then returns to IDLE. Fields hold until the next start.
- Error precedence within a cycle: start > line_valid abort > interpreter error > character handling.
- Latency: done asserts exactly one cycle after the cycle carrying the terminating newline.

Test Plan:
- R format, stream "r05, r12, r31\n" → reg_valid high throughout, imm_valid low; done pulses 1 cycle after "\n"; rd=5, rs1=12, rs2=31, error=0.
- I format, "r01, r02, 100\n" with the immediate interpreter model returning 100 → imm_valid rises the cycle after the second ","; rd=1, rs1=2, imm=100, done=1.
- S format, "r07, r03, 8\n" → rs2=7, rs1=3, imm=8, rd=0.
- R format, "r05, r12\n" → error=1 and stays 1; no done; a following start with format 4 clears error.
- format_in=6 → error=1 the cycle after start; reg_valid and imm_valid stay 0.
- U format, "r10," then line_valid drops → IDLE, busy=0, error=0, done=0. Also: reg_error injected mid-line → error=1.

Source files
------------

// File: rtl/operand_sequencer.sv
// Operand sequencer: walks the operand slots of one decoded instruction format,
// steering the ASCII stream to the register or immediate interpreter and latching results.
module operand_sequencer #(
    parameter int IMM_WIDTH = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start,
    input  logic [2:0]           format_in,
    input  logic                 line_valid,
    input  logic                 new_character,
    input  logic [7:0]           incoming_ascii,
    input  logic                 reg_done,
    input  logic                 reg_error,
    input  logic [4:0]           reg_value,
    input  logic                 imm_done,
    input  logic                 imm_error,
    input  logic [IMM_WIDTH-1:0] imm_value,
    output logic                 reg_valid,
    output logic                 imm_valid,
    output logic [4:0]           rd,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [IMM_WIDTH-1:0] imm,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPERAND = 2'd1,
        DONE    = 2'd2,
        ERROR   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        F_RD  = 2'd0,
        F_RS1 = 2'd1,
        F_RS2 = 2'd2,
        F_IMM = 2'd3
    } field_t;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_J = 3'd5;

    state_t               state_reg, state_next;
    logic [2:0]           fmt_reg, fmt_next;
    logic [1:0]           op_idx_reg, op_idx_next;
    logic [4:0]           rd_reg, rd_next;
    logic [4:0]           rs1_reg, rs1_next;
    logic [4:0]           rs2_reg, rs2_next;
    logic [IMM_WIDTH-1:0] imm_reg, imm_next;

    field_t slot_field;
    logic   last_slot;
    logic   slot_is_imm;
    logic   sel_done;
    logic   sel_error;
    logic   is_delim;
    logic   is_newline;

    // Which field the current slot fills, in the format's source-operand order.
    always_comb begin
        slot_field = F_RD;
        case (fmt_reg)
            FMT_R: begin
                case (op_idx_reg)
                    2'd0:    slot_field = F_RD;
                    2'd1:    slot_field = F_RS1;
                    default: slot_field = F_RS2;
                endcase
            end
            FMT_I: begin
                case (op_idx_reg)
                    2'd0:    slot_field = F_RD;
                    2'd1:    slot_field = F_RS1;
                    default: slot_field = F_IMM;
                endcase
            end
            FMT_S: begin
                case (op_idx_reg)
                    2'd0:    slot_field = F_RS2;
                    2'd1:    slot_field = F_RS1;
                    default: slot_field = F_IMM;
                endcase
            end
            FMT_B: begin
                case (op_idx_reg)
                    2'd0:    slot_field = F_RS1;
                    2'd1:    slot_field = F_RS2;
                    default: slot_field = F_IMM;
                endcase
            end
            default: begin
                slot_field = (op_idx_reg == 2'd0) ? F_RD : F_IMM;
            end
        endcase
    end

    assign last_slot   = (fmt_reg > FMT_B) ? (op_idx_reg == 2'd1) : (op_idx_reg == 2'd2);
    assign slot_is_imm = (slot_field == F_IMM);
    assign sel_done    = slot_is_imm ? imm_done : reg_done;
    assign sel_error   = slot_is_imm ? imm_error : reg_error;
    assign is_delim    = new_character && ((incoming_ascii == 8'h20) || (incoming_ascii == 8'h2C));
    assign is_newline  = new_character && (incoming_ascii == 8'h0A);

    always_comb begin
        state_next  = state_reg;
        fmt_next    = fmt_reg;
        op_idx_next = op_idx_reg;
        rd_next     = rd_reg;
        rs1_next    = rs1_reg;
        rs2_next    = rs2_reg;
        imm_next    = imm_reg;

        if (start) begin
            if (format_in <= FMT_J) begin
                fmt_next    = format_in;
                op_idx_next = 2'd0;
                rd_next     = '0;
                rs1_next    = '0;
                rs2_next    = '0;
                imm_next    = '0;
                state_next  = OPERAND;
            end else begin
                state_next  = ERROR;
            end
        end else begin
            case (state_reg)
                OPERAND: begin
                    if (!line_valid) begin
                        state_next = IDLE;
                    end else if (sel_error) begin
                        state_next = ERROR;
                    end else begin
                        // Track the interpreter's running result; the value held
                        // when the terminator arrives is the one that sticks.
                        if (sel_done) begin
                            case (slot_field)
                                F_RD:    rd_next  = reg_value;
                                F_RS1:   rs1_next = reg_value;
                                F_RS2:   rs2_next = reg_value;
                                default: imm_next = imm_value;
                            endcase
                        end
                        if (is_delim && sel_done) begin
                            if (last_slot) begin
                                state_next = ERROR;
                            end else begin
                                op_idx_next = op_idx_reg + 2'd1;
                            end
                        end else if (is_newline) begin
                            state_next = (sel_done && last_slot) ? DONE : ERROR;
                        end
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg  <= IDLE;
            fmt_reg    <= 3'd0;
            op_idx_reg <= 2'd0;
            rd_reg     <= '0;
            rs1_reg    <= '0;
            rs2_reg    <= '0;
            imm_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            fmt_reg    <= fmt_next;
            op_idx_reg <= op_idx_next;
            rd_reg     <= rd_next;
            rs1_reg    <= rs1_next;
            rs2_reg    <= rs2_next;
            imm_reg    <= imm_next;
        end
    end

    assign reg_valid = (state_reg == OPERAND) && !slot_is_imm && line_valid;
    assign imm_valid = (state_reg == OPERAND) && slot_is_imm && line_valid;
    assign busy      = (state_reg == OPERAND);
    assign done      = (state_reg == DONE);
    assign error     = (state_reg == ERROR);
    assign rd        = rd_reg;
    assign rs1       = rs1_reg;
    assign rs2       = rs2_reg;
    assign imm       = imm_reg;

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer with simple register/immediate interpreter models
// and a scoreboard of expected line outcomes.
module tb_operand_sequencer;

    localparam int IMM_WIDTH = 32;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 start;
    logic [2:0]           format_in;
    logic                 line_valid;
    logic                 new_character;
    logic [7:0]           incoming_ascii;
    logic                 reg_done;
    logic                 reg_error;
    logic [4:0]           reg_value;
    logic                 imm_done;
    logic                 imm_error;
    logic [IMM_WIDTH-1:0] imm_value;
    logic                 reg_valid;
    logic                 imm_valid;
    logic [4:0]           rd, rs1, rs2;
    logic [IMM_WIDTH-1:0] imm;
    logic                 busy, done, error;

    operand_sequencer #(.IMM_WIDTH(IMM_WIDTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start(start), .format_in(format_in),
        .line_valid(line_valid), .new_character(new_character), .incoming_ascii(incoming_ascii),
        .reg_done(reg_done), .reg_error(reg_error), .reg_value(reg_value),
        .imm_done(imm_done), .imm_error(imm_error), .imm_value(imm_value),
        .reg_valid(reg_valid), .imm_valid(imm_valid),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk_in = ~clk_in;

    // Interpreter models: decimal digits accumulate, done after the first digit,
    // any terminator (space, comma, newline) or 'r' restarts the field.
    logic [31:0] racc, iacc;
    logic        rdone, idone;
    logic        inject_reg_err;

    function automatic logic is_term(input logic [7:0] c);
        return (c == 8'h20) || (c == 8'h2C) || (c == 8'h0A);
    endfunction

    always @(posedge clk_in) begin
        if (rst_in || start) begin
            racc <= 0; rdone <= 1'b0;
        end else if (reg_valid && new_character) begin
            if (is_term(incoming_ascii) || incoming_ascii == 8'h72) begin
                racc <= 0; rdone <= 1'b0;
            end else if (incoming_ascii >= 8'h30 && incoming_ascii <= 8'h39) begin
                racc <= racc * 10 + 32'(incoming_ascii - 8'h30); rdone <= 1'b1;
            end
        end
    end

    always @(posedge clk_in) begin
        if (rst_in || start) begin
            iacc <= 0; idone <= 1'b0;
        end else if (imm_valid && new_character) begin
            if (is_term(incoming_ascii)) begin
                iacc <= 0; idone <= 1'b0;
            end else if (incoming_ascii >= 8'h30 && incoming_ascii <= 8'h39) begin
                iacc <= iacc * 10 + 32'(incoming_ascii - 8'h30); idone <= 1'b1;
            end
        end
    end

    assign reg_done  = rdone;
    assign reg_value = racc[4:0];
    assign reg_error = inject_reg_err;
    assign imm_done  = idone;
    assign imm_value = iacc[IMM_WIDTH-1:0];
    assign imm_error = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("[TB] ok %s = %0d", tag, obs);
        end
    endtask

    typedef struct packed {
        logic        is_err;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } exp_t;

    exp_t sb_q[$];

    task automatic push(input logic e, input int d, input int s1, input int s2, input int im);
        exp_t x;
        x.is_err = e; x.rd = 5'(d); x.rs1 = 5'(s1); x.rs2 = 5'(s2); x.imm = 32'(im);
        sb_q.push_back(x);
    endtask

    // Scoreboard monitor: each done pulse or rising error is one line outcome.
    initial begin : monitor
        logic err_prev;
        exp_t e;
        err_prev = 1'b0;
        forever begin
            @(negedge clk_in);
            if (!rst_in && (done || (error && !err_prev))) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_outcome", 32'(error), 32'(2));
                end else begin
                    e = sb_q.pop_front();
                    check("sb_outcome_is_err", 32'(error), 32'(e.is_err));
                    if (!e.is_err) begin
                        check("sb_rd", 32'(rd), 32'(e.rd));
                        check("sb_rs1", 32'(rs1), 32'(e.rs1));
                        check("sb_rs2", 32'(rs2), 32'(e.rs2));
                        check("sb_imm", imm, e.imm);
                    end
                end
            end
            err_prev = error;
        end
    end

    task automatic do_start(input logic [2:0] f);
        @(negedge clk_in);
        start = 1'b1; format_in = f; new_character = 1'b0;
        @(negedge clk_in);
        start = 1'b0;
    endtask

    // mode 1: reg_valid high / imm_valid low on every char; mode 2: imm_valid rises after 2nd comma.
    // end_chk: 1 expect done pulse after newline, 2 expect no done, 0 no end check.
    task automatic send_line(input string s, input int mode, input int end_chk);
        int commas = 0;
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            @(negedge clk_in);
            new_character = 1'b1; incoming_ascii = c;
            #1;
            if (mode == 1) begin
                check("r_reg_valid", 32'(reg_valid), 32'(1));
                check("r_imm_valid", 32'(imm_valid), 32'(0));
            end
            if (mode == 2 && c == 8'h2C && commas == 1)
                check("imm_valid_before_rise", 32'(imm_valid), 32'(0));
            if (mode == 2 && commas == 2 && s[i-1] == 8'h2C)
                check("imm_valid_rise", 32'(imm_valid), 32'(1));
            if (c == 8'h2C) commas++;
        end
        @(negedge clk_in);
        new_character = 1'b0;
        #1;
        if (end_chk == 1) begin
            check("done_latency", 32'(done), 32'(1));
            check("error_clear", 32'(error), 32'(0));
            @(negedge clk_in); #1;
            check("done_one_cycle", 32'(done), 32'(0));
        end else if (end_chk == 2) begin
            check("no_done", 32'(done), 32'(0));
        end
    endtask

    initial begin
        rst_in = 1'b1; start = 1'b0; format_in = 3'd0; line_valid = 1'b1;
        new_character = 1'b0; incoming_ascii = 8'h00; inject_reg_err = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_error", 32'(error), 32'(0));
        check("rst_reg_valid", 32'(reg_valid), 32'(0));
        check("rst_imm_valid", 32'(imm_valid), 32'(0));
        check("rst_rd", 32'(rd), 32'(0));
        check("rst_rs1", 32'(rs1), 32'(0));
        check("rst_rs2", 32'(rs2), 32'(0));
        check("rst_imm", imm, 32'(0));

        // R format: rd, rs1, rs2
        push(1'b0, 5, 12, 31, 0);
        do_start(3'd0);
        send_line("r05, r12, r31\n", 1, 1);

        // I format: rd, rs1, imm
        push(1'b0, 1, 2, 0, 100);
        do_start(3'd1);
        send_line("r01, r02, 100\n", 2, 1);

        // S format: rs2, rs1, imm
        push(1'b0, 0, 3, 7, 8);
        do_start(3'd2);
        send_line("r07, r03, 8\n", 0, 1);

        // B format: rs1, rs2, imm
        push(1'b0, 0, 4, 9, 77);
        do_start(3'd3);
        send_line("r04, r09, 77\n", 0, 1);

        // R format missing an operand
        push(1'b1, 0, 0, 0, 0);
        do_start(3'd0);
        send_line("r05, r12\n", 0, 2);
        check("missing_err", 32'(error), 32'(1));
        repeat (3) @(negedge clk_in);
        #1;
        check("missing_err_held", 32'(error), 32'(1));

        // U format start clears error, then a full line
        push(1'b0, 10, 0, 0, 4095);
        do_start(3'd4);
        #1;
        check("u_start_err_clear", 32'(error), 32'(0));
        check("u_start_busy", 32'(busy), 32'(1));
        send_line("r10, 4095\n", 0, 1);

        // Illegal format
        push(1'b1, 0, 0, 0, 0);
        do_start(3'd6);
        #1;
        check("illegal_err", 32'(error), 32'(1));
        check("illegal_reg_valid", 32'(reg_valid), 32'(0));
        check("illegal_imm_valid", 32'(imm_valid), 32'(0));
        @(negedge clk_in); #1;
        check("illegal_err_held", 32'(error), 32'(1));
        check("illegal_reg_valid_held", 32'(reg_valid), 32'(0));

        // J format with an extra operand after the immediate
        push(1'b1, 0, 0, 0, 0);
        do_start(3'd5);
        send_line("r03, 12, ", 0, 0);
        check("extra_operand_err", 32'(error), 32'(1));

        // U format aborted by line_valid
        do_start(3'd4);
        send_line("r10,", 0, 0);
        @(negedge clk_in);
        line_valid = 1'b0;
        @(negedge clk_in); #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_error", 32'(error), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        line_valid = 1'b1;

        // Register interpreter error mid-line
        push(1'b1, 0, 0, 0, 0);
        do_start(3'd0);
        send_line("r05, r1", 0, 0);
        @(negedge clk_in);
        inject_reg_err = 1'b1;
        @(negedge clk_in);
        inject_reg_err = 1'b0;
        #1;
        check("reg_error_err", 32'(error), 32'(1));

        repeat (3) @(negedge clk_in);
        check("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
